egg_timer_ctrl: RTL and testbench
=================================

EGG_TIMER_CTRL -- requirements
Module: egg_timer_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000000: CLK cycles per one-second tick.
REQ-002 Parameter ALARM_SECS, default 30: alarm auto-silence time in seconds, used only when ALARM_TIMEOUT_EN is defined.
REQ-003 CLK  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 CLR_N  input  1  asynchronous, active-low reset.
REQ-005 BTN_START  input  1  start/pause request; level input, already synchronised to CLK.
REQ-006 BTN_MIN  input  1  increment-minutes request; level input, synchronised.
REQ-007 BTN_SEC  input  1  increment-seconds request; level input, synchronised.
REQ-008 BTN_CLR  input  1  clear-to-idle request; level input, synchronised.
REQ-009 MIN_Q  output  6  minutes remaining, range 0..59.
REQ-010 SEC_Q  output  6  seconds remaining, range 0..59.
REQ-011 RUNNING  output  1  high only while in the RUN state.
REQ-012 ALARM  output  1  high only while in the ALARM state.

Function
REQ-013 Each button SHALL act only on its rising edge (a "press"), registered one cycle after the input goes high.
REQ-014 FSM states SHALL be IDLE, RUN, PAUSE and ALARM; the reset state SHALL be IDLE.
REQ-015 Priority order: a BTN_CLR press from any state SHALL set MIN_Q and SEC_Q to 0 and the state to IDLE next cycle, overriding all other events.
REQ-016 IDLE: a BTN_MIN press SHALL increment MIN_Q, wrapping 59->0; a BTN_SEC press SHALL increment SEC_Q, wrapping 59->0; the two presses in the same cycle SHALL both apply.
REQ-017 IDLE: a BTN_START press with time non-zero SHALL enter RUN and clear the prescaler; with time 00:00 it SHALL be ignored.
REQ-018 Prescaler: counts 0..TICK_DIV-1 only in RUN, holds its value in PAUSE, and emits a one-cycle tick when it equals TICK_DIV-1, then wraps to 0.
REQ-019 RUN tick: if SEC_Q>0 then SEC_Q-1; else if MIN_Q>0 then SEC_Q=59 and MIN_Q-1 in the same cycle.
REQ-020 RUN: the decrement that yields 00:00 SHALL enter ALARM in that same update.
REQ-021 RUN: a BTN_START press SHALL enter PAUSE; if a tick coincides with it, the press wins and no decrement occurs.
REQ-022 RUN and PAUSE: BTN_MIN and BTN_SEC presses SHALL be ignored.
REQ-023 PAUSE: a BTN_START press SHALL return to RUN with the prescaler value retained.
REQ-024 ALARM: any BTN_START, BTN_MIN or BTN_SEC press SHALL enter IDLE, with time left at 00:00.
REQ-025 Time values SHALL never leave the range 0..59; there SHALL be no decrement below 00:00.

Reset
REQ-026 While CLR_N=0: state=IDLE, MIN_Q=0, SEC_Q=0, RUNNING=0, ALARM=0, prescaler=0, edge-detect registers=0.
REQ-027 Reset assertion in mid-run SHALL abort immediately, asynchronously.
REQ-028 The first press SHALL be recognised only on a 0->1 transition after CLR_N rises; a button held high through reset SHALL NOT count.

Configuration
REQ-029 Macro ALARM_TIMEOUT_EN defined: in ALARM the prescaler SHALL run, and after ALARM_SECS ticks the state SHALL return to IDLE automatically.
REQ-030 ALARM_TIMEOUT_EN undefined: ALARM SHALL persist until a press or reset, and no timeout counter SHALL exist.

Structure
REQ-031 Package egg_timer_pkg SHALL hold the state enum (IDLE/RUN/PAUSE/ALARM), the constant MAX_SEC=59 and the time width constant 6.
REQ-032 Sub-module btn_edge (one register plus rising-edge pulse, async active-low clear) SHALL be instantiated once per button.

Verification (TICK_DIV=4)
REQ-033 BTN_SEC pressed 61 times in IDLE -> SEC_Q=1; BTN_MIN pressed 60 times -> MIN_Q=0.
REQ-034 Set 01:00, BTN_START -> RUNNING=1; first tick -> 00:59; after 60 ticks (240 cycles) -> ALARM=1, 00:00.
REQ-035 BTN_START at 00:00 in IDLE -> state stays IDLE, RUNNING=0.
REQ-036 Set 00:03, run, press BTN_START on a tick cycle -> PAUSE with 00:03 held; press again -> 00:00 reached after 3 ticks total.
REQ-037 CLR_N pulsed low during RUN at 00:40 -> outputs immediately 00:00, RUNNING=0; holding BTN_SEC through reset produces no increment.
REQ-038 ALARM_TIMEOUT_EN defined, ALARM_SECS=2 -> ALARM clears after 8 cycles; macro undefined -> ALARM stays high until a BTN_SEC press, then IDLE.

Source files
------------

// File: rtl/egg_timer_pkg.sv
// egg_timer_pkg: shared types and constants for the egg timer controller.
//   state_t  : controller states (idle, run, pause, alarm)
//   TIME_W   : width of the minutes/seconds fields
//   MAX_SEC  : largest minutes/seconds value before wrap-around
//   inc_wrap : increment a time field, wrapping MAX_SEC -> 0
package egg_timer_pkg;

  localparam int TIME_W = 6;
  localparam logic [TIME_W-1:0] MAX_SEC = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  function automatic logic [TIME_W-1:0] inc_wrap(input logic [TIME_W-1:0] t);
    logic [TIME_W-1:0] r;
    if (t >= MAX_SEC) begin
      r = 6'd0;
    end else begin
      r = t + 6'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/egg_timer_ctrl_btn_edge.sv
// btn_edge: rising-edge detector for one synchronised button level.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low clear of the history register
//   i_btn   : button level (already synchronised)
//   o_rise  : high for the cycle in which i_btn is 1 and was 0 last cycle
module btn_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_rise
);

  logic r_btn;

  // Previous-cycle copy of the button level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_btn <= 1'b0;
    end else begin
      r_btn <= i_btn;
    end
  end

  assign o_rise = i_btn & ~r_btn;

endmodule

// File: rtl/egg_timer_ctrl.sv
// egg_timer_ctrl: minutes/seconds countdown timer with start/pause, set and clear.
//   CLK        : system clock, all state updates on the rising edge
//   CLR_N      : asynchronous active-low reset
//   BTN_START  : start / pause / acknowledge alarm (acts on rising edge)
//   BTN_MIN    : add one minute while idle; acknowledges alarm
//   BTN_SEC    : add one second while idle; acknowledges alarm
//   BTN_CLR    : clear to 00:00 idle from any state (highest priority)
//   MIN_Q      : minutes remaining (0..59)
//   SEC_Q      : seconds remaining (0..59)
//   RUNNING    : high while counting down
//   ALARM      : high while the alarm is sounding
// Build option: define ALARM_TIMEOUT_EN to silence the alarm automatically
// after ALARM_SECS one-second ticks.
module egg_timer_ctrl
  import egg_timer_pkg::*;
#(
  parameter int TICK_DIV   = 100000000,
  parameter int ALARM_SECS = 30
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              BTN_START,
  input  logic              BTN_MIN,
  input  logic              BTN_SEC,
  input  logic              BTN_CLR,
  output logic [TIME_W-1:0] MIN_Q,
  output logic [TIME_W-1:0] SEC_Q,
  output logic              RUNNING,
  output logic              ALARM
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t            r_state, w_state_nxt;
  logic [TIME_W-1:0] r_min, w_min_nxt;
  logic [TIME_W-1:0] r_sec, w_sec_nxt;
  logic [PW-1:0]     r_presc, w_presc_nxt;
  logic              r_running, r_alarm;
  logic              r_armed;
  logic              w_rise_start, w_rise_min, w_rise_sec, w_rise_clr;
  logic              w_start_p, w_min_p, w_sec_p, w_clr_p;
  logic              w_tick;

`ifdef ALARM_TIMEOUT_EN
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam logic [AW-1:0] ACNT_LAST = AW'(ALARM_SECS - 1);
  logic [AW-1:0] r_acnt, w_acnt_nxt;
`endif

  btn_edge u_edge_start (.i_clk(CLK), .i_rst_n(CLR_N), .i_btn(BTN_START), .o_rise(w_rise_start));
  btn_edge u_edge_min   (.i_clk(CLK), .i_rst_n(CLR_N), .i_btn(BTN_MIN),   .o_rise(w_rise_min));
  btn_edge u_edge_sec   (.i_clk(CLK), .i_rst_n(CLR_N), .i_btn(BTN_SEC),   .o_rise(w_rise_sec));
  btn_edge u_edge_clr   (.i_clk(CLK), .i_rst_n(CLR_N), .i_btn(BTN_CLR),   .o_rise(w_rise_clr));

  // The first cycle after reset only loads the edge history, so a button held
  // through reset never looks like a fresh press.
  assign w_start_p = w_rise_start & r_armed;
  assign w_min_p   = w_rise_min   & r_armed;
  assign w_sec_p   = w_rise_sec   & r_armed;
  assign w_clr_p   = w_rise_clr   & r_armed;

  assign w_tick = (r_presc == PRESC_LAST);

  // State, time, prescaler and registered status outputs.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state   <= ST_IDLE;
      r_min     <= 6'd0;
      r_sec     <= 6'd0;
      r_presc   <= {PW{1'b0}};
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
      r_armed   <= 1'b0;
`ifdef ALARM_TIMEOUT_EN
      r_acnt    <= {AW{1'b0}};
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_min     <= w_min_nxt;
      r_sec     <= w_sec_nxt;
      r_presc   <= w_presc_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_alarm   <= (w_state_nxt == ST_ALARM);
      r_armed   <= 1'b1;
`ifdef ALARM_TIMEOUT_EN
      r_acnt    <= w_acnt_nxt;
`endif
    end
  end

  // Next-state, time update and prescaler control.
  always_comb begin
    w_state_nxt = r_state;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_presc_nxt = r_presc;
`ifdef ALARM_TIMEOUT_EN
    w_acnt_nxt  = {AW{1'b0}};
`endif
    if (w_clr_p) begin
      w_state_nxt = ST_IDLE;
      w_min_nxt   = 6'd0;
      w_sec_nxt   = 6'd0;
      w_presc_nxt = {PW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_min_p) begin
            w_min_nxt = inc_wrap(r_min);
          end else begin
            w_min_nxt = r_min;
          end
          if (w_sec_p) begin
            w_sec_nxt = inc_wrap(r_sec);
          end else begin
            w_sec_nxt = r_sec;
          end
          // Start is judged on the time shown before this cycle's increments.
          if (w_start_p && ((r_min != 6'd0) || (r_sec != 6'd0))) begin
            w_state_nxt = ST_RUN;
            w_presc_nxt = {PW{1'b0}};
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          w_presc_nxt = w_tick ? {PW{1'b0}} : (r_presc + PW'(1));
          if (w_start_p) begin
            // Pause beats a coincident tick: no decrement this cycle.
            w_state_nxt = ST_PAUSE;
          end else if (w_tick) begin
            if (r_sec != 6'd0) begin
              w_sec_nxt = r_sec - 6'd1;
              if ((r_sec == 6'd1) && (r_min == 6'd0)) begin
                w_state_nxt = ST_ALARM;
              end else begin
                w_state_nxt = ST_RUN;
              end
            end else if (r_min != 6'd0) begin
              w_sec_nxt   = MAX_SEC;
              w_min_nxt   = r_min - 6'd1;
              w_state_nxt = ST_RUN;
            end else begin
              w_state_nxt = ST_ALARM;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (w_start_p) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_PAUSE;
          end
        end
        ST_ALARM: begin
          if (w_start_p || w_min_p || w_sec_p) begin
            w_state_nxt = ST_IDLE;
            w_min_nxt   = 6'd0;
            w_sec_nxt   = 6'd0;
            w_presc_nxt = {PW{1'b0}};
          end
`ifdef ALARM_TIMEOUT_EN
          else begin
            w_presc_nxt = w_tick ? {PW{1'b0}} : (r_presc + PW'(1));
            if (w_tick && (r_acnt == ACNT_LAST)) begin
              w_state_nxt = ST_IDLE;
            end else if (w_tick) begin
              w_acnt_nxt = r_acnt + AW'(1);
            end else begin
              w_acnt_nxt = r_acnt;
            end
          end
`else
          else begin
            w_state_nxt = ST_ALARM;
          end
`endif
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_min_nxt   = 6'd0;
          w_sec_nxt   = 6'd0;
          w_presc_nxt = {PW{1'b0}};
        end
      endcase
    end
  end

  assign MIN_Q   = r_min;
  assign SEC_Q   = r_sec;
  assign RUNNING = r_running;
  assign ALARM   = r_alarm;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// tb_egg_timer_ctrl: directed stimulus with a queue-based scoreboard for
// egg_timer_ctrl at TICK_DIV=4, ALARM_SECS=2. Expectations are hand-computed
// and pushed by the stimulus; a separate monitor pops and compares them.
module tb_egg_timer_ctrl;

  logic       CLK;
  logic       CLR_N;
  logic       BTN_START, BTN_MIN, BTN_SEC, BTN_CLR;
  logic [5:0] MIN_Q, SEC_Q;
  logic       RUNNING, ALARM;

  typedef struct {
    string name;
    int    mn;
    int    sc;
    bit    run;
    bit    alm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;

  egg_timer_ctrl #(.TICK_DIV(4), .ALARM_SECS(2)) dut (
    .CLK(CLK), .CLR_N(CLR_N),
    .BTN_START(BTN_START), .BTN_MIN(BTN_MIN), .BTN_SEC(BTN_SEC), .BTN_CLR(BTN_CLR),
    .MIN_Q(MIN_Q), .SEC_Q(SEC_Q), .RUNNING(RUNNING), .ALARM(ALARM)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic expect_out(input string nm, input int mn, input int sc, input bit run, input bit alm);
    exp_t e;
    e.name = nm; e.mn = mn; e.sc = sc; e.run = run; e.alm = alm;
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Called on a negedge: hold the chosen buttons for one clock, release for one.
  task automatic press(input bit s, input bit m, input bit sc, input bit c);
    BTN_START = s; BTN_MIN = m; BTN_SEC = sc; BTN_CLR = c;
    @(negedge CLK);
    BTN_START = 1'b0; BTN_MIN = 1'b0; BTN_SEC = 1'b0; BTN_CLR = 1'b0;
    @(negedge CLK);
  endtask

  // Monitor: compare current DUT outputs against each queued expectation.
  initial begin
    exp_t e;
    forever begin
      wait (pushed != popped);
      e = exp_q.pop_front();
      popped++;
      checks++;
      if ((MIN_Q !== 6'(e.mn)) || (SEC_Q !== 6'(e.sc)) || (RUNNING !== e.run) || (ALARM !== e.alm)) begin
        errors++;
        $display("FAIL %s: got %0d:%0d run=%0b alarm=%0b, want %0d:%0d run=%0b alarm=%0b",
                 e.name, MIN_Q, SEC_Q, RUNNING, ALARM, e.mn, e.sc, e.run, e.alm);
      end
    end
  end

  initial begin
    CLR_N = 1'b0;
    BTN_START = 1'b0; BTN_MIN = 1'b0; BTN_SEC = 1'b0; BTN_CLR = 1'b0;
    wait_cycles(2);
    expect_out("reset_state", 0, 0, 1'b0, 1'b0);
    CLR_N = 1'b1;
    wait_cycles(1);

    // Seconds wrap: 61 presses land on 1.
    for (int i = 0; i < 59; i++) press(1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("sec_59", 0, 59, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("sec_wrap_0", 0, 0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("sec_61", 0, 1, 1'b0, 1'b0);
    // Minutes wrap: 60 presses land on 0.
    for (int i = 0; i < 59; i++) press(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("min_59", 59, 1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("min_wrap_0", 0, 1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("clr_idle", 0, 0, 1'b0, 1'b0);

    // Start at 00:00 is ignored.
    press(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("start_at_zero", 0, 0, 1'b0, 1'b0);

    // 01:00 countdown to alarm.
    press(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("set_01_00", 1, 0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("run_start", 1, 0, 1'b1, 1'b0);
    wait_cycles(2);
    expect_out("run_pre_tick", 1, 0, 1'b1, 1'b0);
    wait_cycles(1);
    expect_out("first_tick", 0, 59, 1'b1, 1'b0);
    wait_cycles(235);
    expect_out("run_00_01", 0, 1, 1'b1, 1'b0);
    wait_cycles(1);
    expect_out("alarm_00_00", 0, 0, 1'b0, 1'b1);
`ifdef ALARM_TIMEOUT_EN
    wait_cycles(7);
    expect_out("alarm_before_timeout", 0, 0, 1'b0, 1'b1);
    wait_cycles(1);
    expect_out("alarm_timeout_idle", 0, 0, 1'b0, 1'b0);
`else
    wait_cycles(10);
    expect_out("alarm_persists", 0, 0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("alarm_ack_sec", 0, 0, 1'b0, 1'b0);
`endif

    // Pause on a tick cycle: press wins, time held, then 3 ticks to alarm.
    for (int i = 0; i < 3; i++) press(1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("set_00_03", 0, 3, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    wait_cycles(2);
    expect_out("run_00_03", 0, 3, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("pause_on_tick", 0, 3, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b1, 1'b0);
    wait_cycles(8);
    expect_out("pause_held", 0, 3, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    wait_cycles(2);
    expect_out("resume_pre_tick", 0, 3, 1'b1, 1'b0);
    wait_cycles(1);
    expect_out("resume_tick1", 0, 2, 1'b1, 1'b0);
    wait_cycles(7);
    expect_out("resume_tick2", 0, 1, 1'b1, 1'b0);
    wait_cycles(1);
    expect_out("resume_alarm", 0, 0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("clr_from_alarm", 0, 0, 1'b0, 1'b0);

    // Asynchronous reset in mid-run with BTN_SEC held through it.
    for (int i = 0; i < 40; i++) press(1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("set_00_40", 0, 40, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("run_00_40", 0, 40, 1'b1, 1'b0);
    wait_cycles(1);
    BTN_SEC = 1'b1;
    #2 CLR_N = 1'b0;
    #1 expect_out("async_reset", 0, 0, 1'b0, 1'b0);
    wait_cycles(2);
    CLR_N = 1'b1;
    wait_cycles(3);
    expect_out("held_btn_no_inc", 0, 0, 1'b0, 1'b0);
    BTN_SEC = 1'b0;
    wait_cycles(1);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("press_after_reset", 0, 1, 1'b0, 1'b0);
    // Clear overrides a simultaneous seconds press.
    press(1'b0, 1'b0, 1'b1, 1'b1);
    expect_out("clr_priority", 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 50 && pushed != popped; i++) @(negedge CLK);
    if (pushed != popped) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", pushed - popped);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
